// File: rtl/read_sequencer.sv
// Row-read sequencer for a small SRAM array: precharge, word-line, sense, hold.
// Optional build macro READ_PARITY_EN adds rd_par, the XOR of the latched word.
module read_sequencer #(
    parameter int COLS    = 16,
    parameter int ROWS    = 16,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [$clog2(ROWS)-1:0]  rd_addr,
    output logic                     rd_ready,
    output logic                     precharge_en,
    output logic [ROWS-1:0]          wl_sel,
    output logic                     sae,
    input  logic [COLS-1:0]          preout,
    output logic [COLS-1:0]          rd_data,
    output logic                     rd_valid,
`ifdef READ_PARITY_EN
    output logic                     rd_par,
`endif
    input  logic                     rd_taken
);

    localparam int AW = $clog2(ROWS);

    // Counter holds "cycles remaining minus one", so a load of N-1 gives N cycles.
    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_WORDLINE,
        S_SENSE,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [COLS-1:0] data_q, data_d;
    logic            wl_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    cnt_d   = PRE_LOAD;
                    state_d = S_PRECHARGE;
                end
            end
            S_PRECHARGE: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = WL_LOAD;
                    state_d = S_WORDLINE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WORDLINE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SENSE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SENSE: begin
                data_d  = preout;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (rd_taken) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_ready     = (state_q == S_IDLE);
    assign precharge_en = (state_q == S_PRECHARGE);
    assign sae          = (state_q == S_SENSE);
    assign rd_valid     = (state_q == S_HOLD);
    assign rd_data      = data_q;
    assign wl_active    = (state_q == S_WORDLINE) || (state_q == S_SENSE);

    // Per-row decode: an address beyond ROWS-1 matches no row and leaves wl_sel at zero.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_wl
            assign wl_sel[gi] = wl_active && (addr_q == AW'(gi));
        end
    endgenerate

`ifdef READ_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (state_q == S_SENSE) begin
            par_d = ^preout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign rd_par = par_q;
`endif

endmodule

// File: tb/tb_read_sequencer.sv
// Self-checking bench for read_sequencer: per-cycle phase model derived from
// the precharge/word-line/sense/hold timing rules, with randomized traffic.
module tb_read_sequencer;

    localparam int COLS  = 16;
    localparam int ROWS  = 16;
    localparam int ROWS2 = 12;
    localparam int PRE   = 2;
    localparam int WL    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_req, rd_ready, precharge_en, sae, rd_valid, rd_taken;
    logic [3:0]  rd_addr;
    logic [15:0] wl_sel, preout, rd_data;

    logic        rd_req2, rd_ready2, precharge_en2, sae2, rd_valid2, rd_taken2;
    logic [3:0]  rd_addr2;
    logic [11:0] wl_sel2;
    logic [15:0] preout2, rd_data2;

`ifdef READ_PARITY_EN
    logic rd_par, rd_par2;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_data;

    read_sequencer #(.COLS(COLS), .ROWS(ROWS), .PRE_CYC(PRE), .WL_CYC(WL)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .precharge_en(precharge_en), .wl_sel(wl_sel), .sae(sae), .preout(preout),
        .rd_data(rd_data), .rd_valid(rd_valid),
`ifdef READ_PARITY_EN
        .rd_par(rd_par),
`endif
        .rd_taken(rd_taken)
    );

    read_sequencer #(.COLS(COLS), .ROWS(ROWS2), .PRE_CYC(PRE), .WL_CYC(WL)) dut2 (
        .clk(clk), .rst(rst), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ready(rd_ready2),
        .precharge_en(precharge_en2), .wl_sel(wl_sel2), .sae(sae2), .preout(preout2),
        .rd_data(rd_data2), .rd_valid(rd_valid2),
`ifdef READ_PARITY_EN
        .rd_par(rd_par2),
`endif
        .rd_taken(rd_taken2)
    );

    // Starts and ends at #1 after an edge with the DUT in IDLE.
    task automatic run_read(input logic [3:0] addr, input logic use_fixed,
                            input logic [15:0] fixed, input int hold);
        logic [15:0] exp_data;
        logic [15:0] exp_wl;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: rd_ready=%b expected 1", rd_ready);
        end
        rd_req  = 1'b1;
        rd_addr = addr;
        @(posedge clk); #1;
        exp_data = last_data;
        for (int t = 0; t <= PRE + WL; t++) begin
            exp_wl = 16'h0;
            if (t >= PRE) exp_wl[addr] = 1'b1;
            checks++;
            if (precharge_en !== (t < PRE)) begin
                errors++; $display("FAIL precharge t=%0d: got %b expected %b", t, precharge_en, (t < PRE));
            end
            checks++;
            if (wl_sel !== exp_wl) begin
                errors++; $display("FAIL wl_sel t=%0d: got %h expected %h", t, wl_sel, exp_wl);
            end
            checks++;
            if (sae !== (t == PRE + WL)) begin
                errors++; $display("FAIL sae t=%0d: got %b expected %b", t, sae, (t == PRE + WL));
            end
            checks++;
            if ({rd_valid, rd_ready} !== 2'b00) begin
                errors++; $display("FAIL busy_flags t=%0d: valid,ready=%b%b expected 00", t, rd_valid, rd_ready);
            end
            checks++;
            if (rd_data !== last_data) begin
                errors++; $display("FAIL data_retain t=%0d: got %h expected %h", t, rd_data, last_data);
            end
            checks++;
            if (precharge_en === 1'b1 && wl_sel !== 16'h0) begin
                errors++; $display("FAIL overlap t=%0d: precharge=1 wl_sel=%h expected 0", t, wl_sel);
            end
            rd_req   = 1'($urandom);
            rd_addr  = 4'($urandom);
            rd_taken = 1'($urandom);
            preout   = (use_fixed && t == PRE + WL) ? fixed : 16'($urandom);
            if (t == PRE + WL) exp_data = preout;
            @(posedge clk); #1;
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
                errors++; $display("FAIL hold h=%0d: valid=%b data=%h expected 1 %h", h, rd_valid, rd_data, exp_data);
            end
            checks++;
            if ({rd_ready, precharge_en, sae} !== 3'b000 || wl_sel !== 16'h0) begin
                errors++; $display("FAIL hold_ctrl h=%0d: ready,pre,sae=%b%b%b wl=%h expected 000 0000",
                                   h, rd_ready, precharge_en, sae, wl_sel);
            end
`ifdef READ_PARITY_EN
            checks++;
            if (rd_par !== ^exp_data) begin
                errors++; $display("FAIL parity h=%0d: got %b expected %b", h, rd_par, ^exp_data);
            end
`endif
            preout  = 16'($urandom);
            rd_addr = 4'($urandom);
            if (h < hold) begin
                rd_taken = 1'b0;
                rd_req   = 1'b1;
            end else begin
                rd_taken = 1'b1;
                rd_req   = 1'b0;
            end
            @(posedge clk); #1;
        end
        rd_taken = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_ready !== 1'b1 || rd_data !== exp_data) begin
            errors++; $display("FAIL release: valid=%b ready=%b data=%h expected 0 1 %h",
                               rd_valid, rd_ready, rd_data, exp_data);
        end
        last_data = exp_data;
        $display("read addr=%0d data=%h hold=%0d", addr, exp_data, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({precharge_en, sae, rd_valid} !== 3'b000 || wl_sel !== 16'h0 || rd_data !== 16'h0) begin
            errors++; $display("FAIL reset_state: pre,sae,valid=%b%b%b wl=%h data=%h expected all 0",
                               precharge_en, sae, rd_valid, wl_sel, rd_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_ready !== 1'b1 || rd_ready2 !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b %b expected 1 1", rd_ready, rd_ready2);
        end
        last_data = 16'h0;
    endtask

    task automatic test_basic_read();
        run_read(4'd5, 1'b1, 16'hA5C3, 0);
    endtask

    task automatic test_backpressure();
        run_read(4'($urandom), 1'b0, 16'h0, 10);
    endtask

    task automatic test_back_to_back();
        run_read(4'd7, 1'b0, 16'h0, 0);
        run_read(4'd15, 1'b0, 16'h0, 0);
    endtask

    task automatic test_reset_mid();
        logic [3:0]  a;
        logic [15:0] exp_wl;
        a = 4'($urandom);
        rd_req  = 1'b1;
        rd_addr = a;
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (PRE + 1) @(posedge clk);
        #1;
        exp_wl = 16'h0;
        exp_wl[a] = 1'b1;
        checks++;
        if (wl_sel !== exp_wl) begin
            errors++; $display("FAIL mid_wordline: wl_sel=%h expected %h", wl_sel, exp_wl);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({precharge_en, sae, rd_valid} !== 3'b000 || wl_sel !== 16'h0 || rd_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset: pre,sae,valid=%b%b%b wl=%h data=%h expected all 0",
                               precharge_en, sae, rd_valid, wl_sel, rd_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready: got %b expected 1", rd_ready);
        end
        last_data = 16'h0;
        $display("reset mid-read addr=%0d", a);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_read(4'($urandom), 1'b0, 16'h0, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0]  a;
        logic [11:0] exp_wl;
        logic [15:0] exp_data;
        for (int n = 0; n < 4; n++) begin
            a = (n == 0) ? 4'd13 : 4'($urandom);
            rd_req2  = 1'b1;
            rd_addr2 = a;
            @(posedge clk); #1;
            rd_req2  = 1'b0;
            exp_data = 16'h0;
            for (int t = 0; t <= PRE + WL; t++) begin
                exp_wl = 12'h0;
                if (t >= PRE && a < 4'(ROWS2)) exp_wl[a] = 1'b1;
                checks++;
                if (wl_sel2 !== exp_wl || rd_valid2 !== 1'b0) begin
                    errors++; $display("FAIL oor_seq a=%0d t=%0d: wl=%h valid=%b expected %h 0",
                                       a, t, wl_sel2, rd_valid2, exp_wl);
                end
                preout2 = 16'($urandom);
                if (t == PRE + WL) exp_data = preout2;
                @(posedge clk); #1;
            end
            checks++;
            if (rd_valid2 !== 1'b1 || rd_data2 !== exp_data || wl_sel2 !== 12'h0) begin
                errors++; $display("FAIL oor_hold a=%0d: valid=%b data=%h wl=%h expected 1 %h 000",
                                   a, rd_valid2, rd_data2, wl_sel2, exp_data);
            end
            rd_taken2 = 1'b1;
            @(posedge clk); #1;
            rd_taken2 = 1'b0;
            checks++;
            if (rd_ready2 !== 1'b1) begin
                errors++; $display("FAIL oor_release a=%0d: ready=%b expected 1", a, rd_ready2);
            end
            $display("read rows12 addr=%0d data=%h", a, exp_data);
        end
    endtask

`ifdef READ_PARITY_EN
    task automatic test_parity();
        run_read(4'd1, 1'b1, 16'h0001, 0);
        run_read(4'd2, 1'b1, 16'h0003, 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        rd_req = 1'b0; rd_addr = 4'd0; rd_taken = 1'b0; preout = 16'h0;
        rd_req2 = 1'b0; rd_addr2 = 4'd0; rd_taken2 = 1'b0; preout2 = 16'h0;
        last_data = 16'h0;
        test_reset();
        test_basic_read();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_out_of_range();
`ifdef READ_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
